// File: rtl/pc_sequencer.sv
// PC sequencer: boot, fetch handshake and execute-completion target select.
// Tracks EPC, exception cause and the retired-instruction count.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0080,
    parameter int unsigned FETCH_TIMEOUT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        exec_done,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        ext_exc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [31:0] retired,
    output logic [1:0]  state
);

    localparam int unsigned CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_imem_req;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_epc;
    logic [1:0]    r_cause;
    logic [31:0]   r_retired;

    state_t        w_state_next;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_br_target;
    logic [31:0]   w_jmp_target;
    logic [31:0]   w_target;
    logic          w_done;
    logic          w_fetch_to;
    logic          w_jr_misalign;
    logic          w_exc;
    logic [1:0]    w_exc_code;

    assign w_pc_plus4    = pc + 32'd4;
    assign w_br_target   = w_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign w_jmp_target  = {w_pc_plus4[31:28], jump_index, 2'b00};
    assign w_done        = (r_state == S_EXEC) && exec_done && !stall;
    assign w_fetch_to    = (r_state == S_FETCH) && !imem_ack && (r_cnt == TO_LAST);
    assign w_jr_misalign = jr && (jr_addr[1:0] != 2'b00);
    assign w_exc         = w_fetch_to || (w_done && (ext_exc || w_jr_misalign));

    always_comb begin
        w_exc_code = 2'd2;
        if (w_fetch_to)
            w_exc_code = 2'd1;
        else if (ext_exc)
            w_exc_code = 2'd3;
    end

    always_comb begin
        w_target = w_pc_plus4;
        if (jr)
            w_target = jr_addr;
        else if (jump)
            w_target = w_jmp_target;
        else if (branch_taken)
            w_target = w_br_target;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_BOOT:  w_state_next = S_FETCH;
            S_FETCH: if (imem_ack) w_state_next = S_EXEC;
            S_EXEC:  if (w_done) w_state_next = S_FETCH;
            default: w_state_next = S_BOOT;
        endcase
    end

    // PC register reloads every edge, so holding means feeding pc back.
    always_comb begin
        pc_next = pc;
        if (!reset)
            pc_next = RESET_VECTOR;
        else if (r_state == S_BOOT)
            pc_next = RESET_VECTOR;
        else if (w_exc)
            pc_next = EXC_VECTOR;
        else if (w_done)
            pc_next = w_target;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_imem_req <= 1'b0;
            r_cnt      <= '0;
            r_epc      <= '0;
            r_cause    <= '0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_imem_req <= (w_state_next == S_FETCH);
            if ((r_state == S_FETCH) && !imem_ack && !w_fetch_to)
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
            if (w_exc) begin
                r_epc   <= pc;
                r_cause <= w_exc_code;
            end
            if (w_done && !w_exc)
                r_retired <= r_retired + 32'd1;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = pc;
    assign epc       = r_epc;
    assign cause     = r_cause;
    assign retired   = r_retired;
    assign state     = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an external PC register model.
// Expected completions are queued and popped when the DUT completes.
module tb_pc_sequencer;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXV = 32'h0000_0080;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = 32'hDEAD_BEEF;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic        ext_exc = 1'b0;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] retired;
    logic [1:0]  state;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .exec_done(exec_done), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
        .ext_exc(ext_exc), .epc(epc), .cause(cause), .retired(retired),
        .state(state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) pc <= pc_next;

    typedef struct {
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] ja;
        logic        ext;
    } ctrl_t;

    typedef struct {
        logic [31:0] pc_next;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [31:0] retired;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] m_epc = '0;
    logic [1:0]  m_cause = '0;
    logic [31:0] m_retired = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] p, input ctrl_t c);
        exp_t e;
        logic [31:0] off;
        e.cause   = m_cause;
        e.epc     = m_epc;
        e.retired = m_retired;
        off = {{16{c.imm[15]}}, c.imm} * 32'd4;
        if (c.ext) begin
            e.pc_next = EXV; e.cause = 2'd3; e.epc = p;
        end else if (c.jr && (c.ja % 4 != 0)) begin
            e.pc_next = EXV; e.cause = 2'd2; e.epc = p;
        end else begin
            if (c.jr)       e.pc_next = c.ja;
            else if (c.jmp) e.pc_next = ((p + 32'd4) & 32'hF000_0000) | ({6'd0, c.idx} << 2);
            else if (c.br)  e.pc_next = p + 32'd4 + off;
            else            e.pc_next = p + 32'd4;
            e.retired = m_retired + 32'd1;
        end
        return e;
    endfunction

    // Entered just after a negedge in the first FETCH cycle.
    task automatic do_fetch(input int lat);
        for (int i = 0; i < lat; i++) begin
            imem_ack = (i == lat - 1);
            #1;
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_hold", pc_next, pc);
            @(negedge clock);
        end
        imem_ack = 1'b0;
        #1;
        chk("fetch_to_exec", 32'(state), 32'd2);
        chk("exec_req_low", 32'(imem_req), 32'd0);
    endtask

    task automatic do_exec(input int dly, input int stall_cyc, input ctrl_t c);
        exp_t e;
        for (int i = 0; i < dly; i++) begin
            #1;
            chk("exec_hold", pc_next, pc);
            @(negedge clock);
        end
        exec_done = 1'b1; stall = (stall_cyc > 0);
        branch_taken = c.br; branch_imm = c.imm; jump = c.jmp;
        jump_index = c.idx; jr = c.jr; jr_addr = c.ja; ext_exc = c.ext;
        for (int i = 0; i < stall_cyc; i++) begin
            #1;
            chk("stall_hold", pc_next, pc);
            chk("stall_state", 32'(state), 32'd2);
            @(negedge clock);
        end
        stall = 1'b0;
        sb.push_back(model(pc, c));
        #1;
        e = sb.pop_front();
        chk("exec_pc_next", pc_next, e.pc_next);
        @(negedge clock);
        exec_done = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; ext_exc = 1'b0;
        #1;
        chk("pc_loaded", pc, e.pc_next);
        chk("back_fetch", 32'(state), 32'd1);
        chk("retired", retired, e.retired);
        chk("cause", 32'(cause), 32'(e.cause));
        chk("epc", epc, e.epc);
        m_retired = e.retired; m_cause = e.cause; m_epc = e.epc;
    endtask

    function automatic ctrl_t cz();
        ctrl_t c;
        c.br = 0; c.imm = '0; c.jmp = 0; c.idx = '0; c.jr = 0; c.ja = '0; c.ext = 0;
        return c;
    endfunction

    initial begin
        ctrl_t c;
        logic [31:0] pc_save;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc_next", pc_next, RV);
        reset = 1'b1;
        #1;
        chk("boot_state", 32'(state), 32'd0);
        chk("boot_pc_next", pc_next, RV);
        @(negedge clock);
        chk("boot_to_fetch", 32'(state), 32'd1);
        chk("pc_after_boot", pc, RV);

        do_fetch(2);
        do_exec(1, 0, cz());
        chk("first_pc4", pc, 32'h4);

        c = cz(); c.jr = 1; c.ja = 32'h100;
        do_fetch(1); do_exec(0, 0, c);
        c = cz(); c.br = 1; c.imm = 16'hFFFE;
        do_fetch(1); do_exec(0, 0, c);
        chk("br_back", pc, 32'h0FC);
        c = cz(); c.jr = 1; c.ja = 32'h100;
        do_fetch(1); do_exec(0, 0, c);
        c = cz(); c.br = 1; c.imm = 16'h0003;
        do_fetch(1); do_exec(0, 0, c);
        chk("br_fwd", pc, 32'h110);

        c = cz(); c.jr = 1; c.ja = 32'hA000_0010;
        do_fetch(1); do_exec(0, 0, c);
        c = cz(); c.jmp = 1; c.idx = 26'h0000040;
        do_fetch(1); do_exec(0, 0, c);
        chk("jump", pc, 32'hA000_0100);
        c = cz(); c.jr = 1; c.ja = 32'h200; c.jmp = 1; c.idx = 26'h3; c.br = 1; c.imm = 16'h7;
        do_fetch(1); do_exec(0, 0, c);
        chk("jr_wins", pc, 32'h200);

        c = cz(); c.jr = 1; c.ja = 32'h202;
        do_fetch(1); do_exec(0, 0, c);
        chk("misalign_cause", 32'(cause), 32'd2);
        chk("misalign_epc", epc, 32'h200);

        pc_save = pc;
        for (int i = 0; i < 8; i++) begin
            imem_ack = 1'b0;
            #1;
            if (i < 7) chk("to_hold", pc_next, pc);
            else       chk("to_pc_next", pc_next, EXV);
            @(negedge clock);
        end
        #1;
        chk("to_pc", pc, EXV);
        chk("to_cause", 32'(cause), 32'd1);
        chk("to_epc", epc, pc_save);
        chk("to_state", 32'(state), 32'd1);
        m_cause = 2'd1; m_epc = pc_save;

        do_fetch(8);
        chk("ack8_cause", 32'(cause), 32'd1);
        do_exec(0, 0, cz());
        chk("ack8_seq", pc, EXV + 32'd4);

        do_fetch(1);
        do_exec(0, 5, cz());
        c = cz(); c.ext = 1;
        do_fetch(2); do_exec(1, 3, c);
        chk("ext_cause", 32'(cause), 32'd3);

        do_fetch(1);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_retired", retired, 32'd0);
        chk("async_pc_next", pc_next, RV);
        chk("async_req", 32'(imem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle controller that sequences the program counter register.
- The PC register loads `pc_input` on every rising clock edge. This block drives that input, holding the current value or supplying the next fetch address.
- Runs the instruction-fetch handshake with instruction memory and selects sequential, branch, jump, jr or exception targets.
- Keeps the exception PC (EPC), the exception cause and a retired-instruction counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address loaded after reset.
- EXC_VECTOR, 32'h0000_0080, exception handler address.
- FETCH_TIMEOUT, 8, maximum cycles in FETCH without `imem_ack` before a bus-timeout exception; must be ≥2.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- pc  input  32  current value of the PC register
- pc_next  output  32  drives the PC register `pc_input`; combinational
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals `pc` while `imem_req` is high
- imem_ack  input  1  instruction memory has returned the instruction
- exec_done  input  1  datapath has finished the current instruction
- stall  input  1  datapath requests hold; exec_done is ignored while high
- branch_taken  input  1  conditional branch taken
- branch_imm  input  16  branch offset, in words
- jump  input  1  j/jal
- jump_index  input  26  jump target index
- jr  input  1  jr/jalr
- jr_addr  input  32  register jump target
- ext_exc  input  1  external exception request
- epc  output  32  PC of the instruction that faulted
- cause  output  2  0 none, 1 fetch timeout, 2 misaligned target, 3 external
- retired  output  32  count of completed instructions; wraps
- state  output  2  0 BOOT, 1 FETCH, 2 EXEC

Behaviour:
- Reset is asynchronous and active-low, on `clock`/`reset` as decided. While reset is low:
  - state = BOOT; epc = 0; cause = 0; retired = 0; timeout counter = 0.
  - imem_req = 0; pc_next = RESET_VECTOR.
  - Reset low in the middle of a fetch or execute aborts it with no update to epc, cause or retired.
- BOOT (one cycle): pc_next = RESET_VECTOR, so the PC register loads it at the edge. Next state is FETCH.
- FETCH:
  - imem_req = 1; pc_next = pc (hold); the timeout counter increments each cycle.
  - imem_ack → EXEC and the counter clears. Fetch latency is 1 cycle minimum.
  - Counter reaches FETCH_TIMEOUT-1 without ack → exception, cause = 1.
  - If imem_ack and the timeout arrive in the same cycle, the ack wins.
- EXEC:
  - imem_req = 0; pc_next = pc while stall is high or exec_done is low.
  - On exec_done & !stall, the target is chosen by this priority: ext_exc > jr > jump > branch_taken > sequential.
    - sequential = pc + 4.
    - branch = pc + 4 + (sign-extended branch_imm << 2).
    - jump = {pc_plus4[31:28], jump_index, 2'b00}.
    - jr = jr_addr.
  - All arithmetic is modulo 2^32; wrap-around is silent.
  - A jr target with bits [1:0] ≠ 0 → exception, cause = 2. Branch and jump targets cannot be misaligned.
  - A normal (non-exception) completion sets pc_next = target, increments retired, and goes to FETCH.
  - The PC register updates at the same edge the FSM leaves EXEC.
- Exception (from FETCH or EXEC):
  - pc_next = EXC_VECTOR; epc <= pc; cause <= code; retired does not increment; next state is FETCH.
  - ext_exc is sampled only at EXEC completion. While stall is high, ext_exc is held off.
- cause and epc hold their value until the next exception or reset.
- At most one PC update happens per instruction. pc_next ≠ pc only in BOOT, on EXEC completion, or on an exception.

Test Plan:
- Reset release, ack 2 cycles after request, exec_done 1 cycle after ack → PC reads 0 after BOOT, then 4. imem_req is high exactly during FETCH; retired = 1.
- pc = 0x100, branch_taken, branch_imm = 16'hFFFE, exec_done → pc_next = 0x0FC. Repeat with imem = 0x0003 → pc_next = 0x110.
- pc = 0xA000_0010, jump, jump_index = 26'h0000040 → pc_next = 0xA000_0100. Assert jr, jump and branch together with jr_addr = 0x200 → 0x200 (jr wins).
- jr_addr = 0x202 → pc_next = 0x80, epc = pc, cause = 2, retired unchanged.
- imem_ack held low for 8 FETCH cycles → PC becomes 0x80 and cause = 1. A second run with ack arriving in cycle 8 → no exception.
- stall high for 5 cycles with exec_done high → pc_next = pc throughout; advances 1 cycle after stall drops. Reset pulsed low in EXEC → state = BOOT and retired = 0 immediately (asynchronous).
